// File: rtl/csr_axil_slave.sv
// AXI4-lite slave front-end for the CSR bank: joins AW/W, decodes byte addresses
// into word indices, issues one-cycle read/write strobes and holds B/R until accepted.
module csr_axil_slave #(
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int CSR_DATA_WIDTH = 32,
  parameter int NB_REGS        = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  // write address
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [CSR_ADDR_WIDTH-1:0]     awaddr,
  input  logic [1:0]                    awprot,
  // write data
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [CSR_DATA_WIDTH-1:0]     wdata,
  input  logic [CSR_DATA_WIDTH/8-1:0]   wstrb,
  // write response
  output logic                          bvalid,
  input  logic                          bready,
  output logic [1:0]                    bresp,
  // read address
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [CSR_ADDR_WIDTH-1:0]     araddr,
  input  logic [1:0]                    arprot,
  // read data
  output logic                          rvalid,
  input  logic                          rready,
  output logic [CSR_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                    rresp,
  // register bank side
  output logic                          reg_wen,
  output logic [$clog2(NB_REGS)-1:0]    reg_waddr,
  output logic [CSR_DATA_WIDTH-1:0]     reg_wdata,
  output logic [CSR_DATA_WIDTH/8-1:0]   reg_wstrb,
  output logic                          reg_ren,
  output logic [$clog2(NB_REGS)-1:0]    reg_raddr,
  input  logic [CSR_DATA_WIDTH-1:0]     reg_rdata
);

  localparam int STRB_W   = CSR_DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NB_REGS);
  localparam int ADDR_LSB = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACCESS, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_WAIT, R_RESP} r_state_t;

  function automatic logic addr_ok(input logic [CSR_ADDR_WIDTH-1:0] addr);
    logic [CSR_ADDR_WIDTH-1:0] word;
    word = addr >> ADDR_LSB;
    return 32'(word) < NB_REGS;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [CSR_ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> ADDR_LSB);
  endfunction

  w_state_t                  w_state;
  r_state_t                  r_state;
  logic                      live;
  logic                      aw_done, w_done, w_err, r_err;
  logic [CSR_ADDR_WIDTH-1:0] aw_addr_q;
  logic [CSR_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;
  logic                      aw_hs, w_hs;
  logic [CSR_ADDR_WIDTH-1:0] waddr_sel;
  logic [CSR_DATA_WIDTH-1:0] wdata_sel;
  logic [STRB_W-1:0]         wstrb_sel;
  logic                      unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Held low through reset and set by the first edge that samples aresetn high.
  always_ff @(posedge aclk) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // NOTE: readies are decoded from state, not registered, so they drop in the
  // same cycle the FSM leaves idle and a second beat can never be accepted.
  assign awready = live && (w_state == W_IDLE) && !aw_done;
  assign wready  = live && (w_state == W_IDLE) && !w_done;
  assign arready = live && (r_state == R_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // A beat arriving in the joining cycle is used directly, otherwise the held copy.
  assign waddr_sel = aw_done ? aw_addr_q : awaddr;
  assign wdata_sel = w_done  ? w_data_q  : wdata;
  assign wstrb_sel = w_done  ? w_strb_q  : wstrb;

  // NOTE: sequential state uses non-blocking assignments only, so every block
  // sees the pre-edge value of every register regardless of evaluation order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: the holding registers are cleared too; they are few and a defined
      // value keeps the bank-side ports at 0 after reset.
      w_state   <= W_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_err     <= 1'b0;
      reg_wen   <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      reg_wen <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_done   <= 1'b1;
            aw_addr_q <= awaddr;
          end
          if (w_hs) begin
            w_done   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            reg_wen   <= addr_ok(waddr_sel);
            reg_waddr <= addr_idx(waddr_sel);
            reg_wdata <= wdata_sel;
            reg_wstrb <= wstrb_sel;
            w_err     <= !addr_ok(waddr_sel);
            w_state   <= W_ACCESS;
          end
        end
        W_ACCESS: begin
          bvalid  <= 1'b1;
          bresp   <= w_err ? RESP_SLVERR : RESP_OKAY;
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      r_err     <= 1'b0;
      reg_ren   <= 1'b0;
      reg_raddr <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      reg_ren <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            reg_ren   <= addr_ok(araddr);
            reg_raddr <= addr_idx(araddr);
            r_err     <= !addr_ok(araddr);
            r_state   <= R_ACCESS;
          end
        end
        R_ACCESS: r_state <= R_WAIT;
        // The bank answers one cycle after the strobe, i.e. during this state.
        R_WAIT: begin
          rdata   <= r_err ? '0 : reg_rdata;
          rresp   <= r_err ? RESP_SLVERR : RESP_OKAY;
          rvalid  <= 1'b1;
          r_state <= R_RESP;
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_axil_slave.sv
// Randomized scoreboard bench for csr_axil_slave: stimulus tasks queue the expected
// strobes and responses, a negedge monitor pops and compares them with timing.
module tb_csr_axil_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [1:0]  awprot, arprot, bresp, rresp;
  logic [31:0] wdata, rdata, reg_wdata, reg_rdata;
  logic [3:0]  wstrb, reg_wstrb;
  logic        reg_wen, reg_ren;
  logic [3:0]  reg_waddr, reg_raddr;

  always #5 aclk = ~aclk;

  csr_axil_slave #(.CSR_ADDR_WIDTH(8), .CSR_DATA_WIDTH(32), .NB_REGS(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ren(reg_ren), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
  );

  typedef struct { logic [3:0] idx; logic [31:0] data; logic [3:0] strb; } wstrobe_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rresp_t;

  wstrobe_t    exp_ws[$];
  logic [3:0]  exp_rs[$];
  logic [1:0]  exp_b[$];
  rresp_t      exp_r[$];
  logic [31:0] model_mem [16];
  logic [31:0] bank [16];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream bank: read data one cycle after reg_ren, garbage otherwise.
  always @(posedge aclk) begin
    if (reg_ren) reg_rdata <= bank[reg_raddr];
    else         reg_rdata <= $urandom;
    if (reg_wen)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) bank[reg_waddr][8*b +: 8] <= reg_wdata[8*b +: 8];
  end

  always @(posedge aclk) begin
    cyc++;
    rst_at_edge = !aresetn;
  end

  // ---------------- monitor ----------------
  int          aw_edge = -1, w_edge = -1, wacc_edge = -1, ar_edge = -1;
  int          last_wen_cyc = -1, last_ren_cyc = -2;
  logic        prev_bvalid = 1'b0, prev_bready = 1'b0, prev_rvalid = 1'b0, prev_rready = 1'b0;
  logic [1:0]  prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;
  wstrobe_t    mon_ws;
  logic [3:0]  mon_rs;
  logic [1:0]  mon_b;
  rresp_t      mon_r;

  always @(negedge aclk) begin
    if (rst_at_edge) begin
      check("readies during reset", {awready, wready, arready}, 3'b000);
      check("valids/strobes during reset", {bvalid, rvalid, reg_wen, reg_ren}, 4'b0000);
      aw_edge = -1; w_edge = -1; wacc_edge = -1; ar_edge = -1;
      prev_bvalid = 1'b0; prev_bready = 1'b0; prev_rvalid = 1'b0; prev_rready = 1'b0;
    end else begin
      if (reg_wen) begin
        if (exp_ws.size() == 0) check("reg_wen with no write pending", reg_wen, 1'b0);
        else begin
          mon_ws = exp_ws.pop_front();
          check("reg_waddr", reg_waddr, mon_ws.idx);
          check("reg_wdata", reg_wdata, mon_ws.data);
          check("reg_wstrb", reg_wstrb, mon_ws.strb);
          check("reg_wen latency", cyc, wacc_edge);
        end
        last_wen_cyc = cyc;
      end
      if (reg_ren) begin
        if (exp_rs.size() == 0) check("reg_ren with no read pending", reg_ren, 1'b0);
        else begin
          mon_rs = exp_rs.pop_front();
          check("reg_raddr", reg_raddr, mon_rs);
          check("reg_ren latency", cyc, ar_edge);
        end
        last_ren_cyc = cyc;
      end
      if (bvalid && !prev_bvalid) begin
        if (exp_b.size() == 0) check("bvalid with no write pending", bvalid, 1'b0);
        else check("bvalid latency", cyc, wacc_edge + 1);
      end
      if (bvalid && prev_bvalid && !prev_bready) begin
        check("bresp stable", bresp, prev_bresp);
        check("awready low in W_RESP", awready, 1'b0);
      end
      if (bvalid && bready && exp_b.size() != 0) begin
        mon_b = exp_b.pop_front();
        check("bresp", bresp, mon_b);
      end
      if (rvalid && !prev_rvalid) begin
        if (exp_r.size() == 0) check("rvalid with no read pending", rvalid, 1'b0);
        else check("rvalid latency", cyc, ar_edge + 2);
      end
      if (rvalid && prev_rvalid && !prev_rready) begin
        check("rdata stable", rdata, prev_rdata);
        check("rresp stable", rresp, prev_rresp);
        check("arready low in R_RESP", arready, 1'b0);
      end
      if (rvalid && rready && exp_r.size() != 0) begin
        mon_r = exp_r.pop_front();
        check("rdata", rdata, mon_r.data);
        check("rresp", rresp, mon_r.resp);
      end
      // Handshakes seen now complete at the coming edge, numbered cyc+1.
      if (awvalid && awready) aw_edge = cyc + 1;
      if (wvalid && wready)   w_edge  = cyc + 1;
      if (aw_edge >= 0 && w_edge >= 0) begin
        wacc_edge = (aw_edge > w_edge) ? aw_edge : w_edge;
        aw_edge = -1;
        w_edge  = -1;
      end
      if (arvalid && arready) ar_edge = cyc + 1;
      prev_bvalid = bvalid; prev_bready = bready; prev_bresp = bresp;
      prev_rvalid = rvalid; prev_rready = rready; prev_rresp = rresp; prev_rdata = rdata;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_aw(input logic [7:0] a, input int d);
    bit hs = 1'b0;
    @(posedge aclk); #1;
    repeat (d) begin @(posedge aclk); #1; end
    awvalid = 1'b1; awaddr = a;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk); hs = awready;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0; awaddr = 8'($urandom);
    if (!hs) check("aw handshake timeout", hs, 1'b1);
  endtask

  task automatic drive_w(input logic [31:0] dat, input logic [3:0] s, input int d);
    bit hs = 1'b0;
    @(posedge aclk); #1;
    repeat (d) begin @(posedge aclk); #1; end
    wvalid = 1'b1; wdata = dat; wstrb = s;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk); hs = wready;
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom);
    if (!hs) check("w handshake timeout", hs, 1'b1);
  endtask

  task automatic drive_ar(input logic [7:0] a);
    bit hs = 1'b0;
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = a;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge aclk); hs = arready;
      @(posedge aclk); #1;
    end
    arvalid = 1'b0; araddr = 8'($urandom);
    if (!hs) check("ar handshake timeout", hs, 1'b1);
  endtask

  task automatic wait_b(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge aclk); seen = bvalid; end
    if (!seen) check("bvalid timeout", seen, 1'b1);
    else begin
      @(posedge aclk); #1;
      repeat (d) begin @(posedge aclk); #1; end
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
    end
  endtask

  task automatic wait_r(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge aclk); seen = rvalid; end
    if (!seen) check("rvalid timeout", seen, 1'b1);
    else begin
      @(posedge aclk); #1;
      repeat (d) begin @(posedge aclk); #1; end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
    end
  endtask

  // Reference model: word index = addr/4, in range below 16, strobed byte merge.
  task automatic expect_write(input logic [7:0] addr, input logic [31:0] dat, input logic [3:0] s);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 16) begin
      exp_ws.push_back('{idx: 4'(idx), data: dat, strb: s});
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
    end
    exp_b.push_back(idx < 16 ? 2'b00 : 2'b10);
  endtask

  // lead > 0: AW goes first by lead cycles; lead < 0: W goes first.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] dat, input logic [3:0] s,
                          input int lead, input int bdly);
    expect_write(addr, dat, s);
    fork
      drive_aw(addr, lead < 0 ? -lead : 0);
      drive_w(dat, s, lead > 0 ? lead : 0);
    join
    wait_b(bdly);
  endtask

  task automatic do_read_exp(input logic [7:0] addr, input logic [31:0] e, input int rdly);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 16) exp_rs.push_back(4'(idx));
    exp_r.push_back('{data: (idx < 16) ? e : 32'h0, resp: (idx < 16) ? 2'b00 : 2'b10});
    drive_ar(addr);
    wait_r(rdly);
  endtask

  task automatic do_read(input logic [7:0] addr, input int rdly);
    logic [31:0] e;
    e = (int'(addr) / 4 < 16) ? model_mem[int'(addr) / 4] : 32'h0;
    do_read_exp(addr, e, rdly);
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    exp_b.delete();
    exp_r.delete();
    repeat (2) begin @(posedge aclk); #1; end
    aresetn = 1'b1;
    repeat (6) begin @(posedge aclk); #1; end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] old3, d;
    bit          seen;
    aresetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("readies after release", {awready, wready, arready}, 3'b111);
    check("bvalid/rvalid after release", {bvalid, rvalid}, 2'b00);
    check("rdata after release", rdata, 32'h0);
    check("bresp/rresp after release", {bresp, rresp}, 4'h0);
    check("reg_waddr/raddr after release", {reg_waddr, reg_raddr}, 8'h0);
    check("reg_wdata/wstrb after release", {reg_wdata, reg_wstrb}, 36'h0);

    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    for (int i = 0; i < 16; i++) do_write(8'(4 * i + $urandom_range(0, 3)), $urandom, 4'hF, 0, 0);

    do_write(8'h18, $urandom, 4'h5, 3, 0);       // AW three cycles before W
    do_write(8'h1C, $urandom, 4'h0, -2, 5);      // W first, all-zero strobe, bready late
    do_write(8'h08, 32'h12345678, 4'hF, 0, 0);
    do_read(8'h08, 4);
    do_write(8'h40, $urandom, 4'hF, 0, 0);       // out of range
    do_read(8'h44, 1);
    do_read(8'h3F, 0);                           // last word, unaligned byte

    old3 = model_mem[3];
    d = $urandom;
    fork
      do_write(8'h0C, d, 4'hF, 0, 1);
      do_read_exp(8'h0C, old3, 2);
    join
    check("concurrent strobes same cycle", last_wen_cyc, last_ren_cyc);
    do_read(8'h0C, 0);

    // Reset while in W_RESP: strobe already issued, response discarded.
    expect_write(8'h10, 32'hA5A5_0F0F, 4'hF);
    fork
      drive_aw(8'h10, 0);
      drive_w(32'hA5A5_0F0F, 4'hF, 0);
    join
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge aclk); seen = bvalid; end
    check("bvalid reached before reset", seen, 1'b1);
    @(posedge aclk); #1;
    pulse_reset();
    @(negedge aclk);
    check("bvalid after aborted write", bvalid, 1'b0);

    // Reset while in R_WAIT.
    exp_rs.push_back(4'd5);
    drive_ar(8'h14);
    @(posedge aclk); #1;
    pulse_reset();
    @(negedge aclk);
    check("rvalid after aborted read", rvalid, 1'b0);

    do_write(8'h20, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(8'h20, 0);
    do_read(8'h10, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom_range(0, 79)), $urandom, 4'($urandom),
                 int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      else
        do_read(8'($urandom_range(0, 79)), int'($urandom_range(0, 3)));
    end

    repeat (10) @(posedge aclk);
    check("write strobes drained", exp_ws.size(), 0);
    check("read strobes drained", exp_rs.size(), 0);
    check("write responses drained", exp_b.size(), 0);
    check("read responses drained", exp_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
